// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: the controller state
// encoding used by both the multiplier and the divider, and the default operand width.
package arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } arith_state_e;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath: operand registers, 2*WIDTH accumulator and the
// shifted-add step, driven by load/step strobes from the controller.
module mul_datapath
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [CNT_W-1:0]   cnt_i,
   output logic [2*WIDTH-1:0] acc_sum_o
);

   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] addend;

   // Multiplicand weighted by the bit position currently at the bottom of B.
   always_comb begin
      addend = '0;
      if (b_q[0]) begin
         addend = {{WIDTH{1'b0}}, a_q} << cnt_i;
      end
   end

   assign acc_sum_o = acc_q + addend;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (clr_i) begin
         a_d   = '0;
         b_d   = '0;
         acc_d = '0;
      end else if (load_i) begin
         a_d   = a_i;
         b_d   = b_i;
         acc_d = '0;
      end else if (step_i) begin
         b_d   = b_q >> 1;
         acc_d = acc_sum_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned multiplier, one multiplier bit per clock, with the same
// start/busy/valid handshake as the sequential divider.
module seq_multiplier
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclr,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] q_out,
   output logic             ovf,
   output logic             busy,
   output logic             valid
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   arith_state_e       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               ovf_q, ovf_d;
   logic               dp_load;
   logic               dp_step;
   logic [2*WIDTH-1:0] acc_sum;

   mul_datapath #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clr_i     (sclr),
      .load_i    (dp_load),
      .step_i    (dp_step),
      .a_i       (a_in),
      .b_i       (b_in),
      .cnt_i     (cnt_q),
      .acc_sum_o (acc_sum)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      dp_load = 1'b0;
      dp_step = 1'b0;
      if (sclr) begin
         state_d = IDLE;
         cnt_d   = '0;
         q_d     = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  dp_load = 1'b1;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               dp_step = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               // Last bit: publish the accumulator including this edge's add.
               if (cnt_q == LastCnt) begin
                  cnt_d   = '0;
                  q_d     = acc_sum[WIDTH-1:0];
                  ovf_d   = |acc_sum[2*WIDTH-1:WIDTH];
                  state_d = DONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q_out = q_q;
   assign ovf   = ovf_q;
   assign busy  = (state_q == RUN);
   assign valid = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: countdown-and-product reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_seq_multiplier;

   localparam int unsigned WIDTH = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sclr;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] q_out;
   logic             ovf;
   logic             busy;
   logic             valid;

   int n_cmp = 0;
   int n_err = 0;

   seq_multiplier #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sclr  (sclr),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .q_out (q_out),
      .ovf   (ovf),
      .busy  (busy),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an accepted start fixes the product; results appear WIDTH edges later.
   int               rem_m     = 0;
   logic [2*WIDTH-1:0] prod_m  = '0;
   logic [WIDTH-1:0] exp_q     = '0;
   logic             exp_ovf   = 1'b0;
   logic             exp_valid = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || sclr) begin
         rem_m     <= 0;
         exp_q     <= '0;
         exp_ovf   <= 1'b0;
         exp_valid <= 1'b0;
      end else begin
         exp_valid <= 1'b0;
         if (rem_m != 0) begin
            rem_m <= rem_m - 1;
            if (rem_m == 1) begin
               exp_q     <= prod_m[WIDTH-1:0];
               exp_ovf   <= (prod_m[2*WIDTH-1:WIDTH] != '0);
               exp_valid <= 1'b1;
            end
         end else if (start) begin
            prod_m <= (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);
            rem_m  <= WIDTH;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", {31'd0, busy}, {31'd0, rem_m != 0});
      check("valid", {31'd0, valid}, {31'd0, exp_valid});
      check("q_out", {22'd0, q_out}, {22'd0, exp_q});
      check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
   end

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int eq, input int eo, input string nm);
      int n;
      int bn;
      bit got;
      @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      n     = 0;
      bn    = 0;
      got   = 1'b0;
      while (!got && n < 3 * WIDTH) begin
         @(negedge clk);
         start = 1'b0;
         n++;
         if (valid) got = 1'b1;
         else if (busy) bn++;
      end
      check({nm, "_got_valid"}, {31'd0, got}, 32'd1);
      check({nm, "_latency"}, n, WIDTH + 1);
      check({nm, "_busy_cycles"}, bn, WIDTH);
      check({nm, "_q"}, {22'd0, q_out}, eq);
      check({nm, "_ovf"}, {31'd0, ovf}, eo);
   endtask

   task automatic watch_no_valid(input string nm);
      int seen;
      seen = 0;
      repeat (3 * WIDTH) begin
         @(negedge clk);
         if (valid) seen++;
      end
      check(nm, seen, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  got;
      rst_n = 1'b0;
      sclr  = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_q", {22'd0, q_out}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;

      do_op(10'd116, 10'd8, 928, 0, "mul_116x8");
      do_op(10'd32, 10'd32, 0, 1, "mul_32x32");
      do_op(10'd1023, 10'd1023, 1, 1, "mul_max");
      do_op(10'd0, 10'd777, 0, 0, "mul_zero");
      do_op(10'd1, 10'd1023, 1023, 0, "mul_1x1023");

      // Start held high; operand change mid-run must not leak into the first result.
      @(negedge clk);
      start = 1'b1;
      a_in  = 10'd3;
      b_in  = 10'd5;
      n     = 0;
      got   = 1'b0;
      while (!got && n < 3 * WIDTH) begin
         @(negedge clk);
         n++;
         if (n == 3) begin
            a_in = 10'd7;
            b_in = 10'd9;
         end
         if (valid) got = 1'b1;
      end
      check("b2b_first_latency", n, WIDTH + 1);
      check("b2b_first_q", {22'd0, q_out}, 32'd15);
      n   = 0;
      got = 1'b0;
      while (!got && n < 3 * WIDTH) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (valid) got = 1'b1;
      end
      check("b2b_second_gap", n, WIDTH + 1);
      check("b2b_second_q", {22'd0, q_out}, 32'd63);

      // Asynchronous reset in the middle of 1023*1023.
      @(negedge clk);
      start = 1'b1;
      a_in  = 10'd1023;
      b_in  = 10'd1023;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_valid", {31'd0, valid}, 32'd0);
      check("arst_q", {22'd0, q_out}, 32'd0);
      check("arst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_valid("arst_no_valid");

      // Synchronous clear in the middle of 1023*1023.
      do_op(10'd116, 10'd8, 928, 0, "pre_sclr");
      @(negedge clk);
      start = 1'b1;
      a_in  = 10'd1023;
      b_in  = 10'd1023;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      sclr = 1'b1;
      #1;
      check("sclr_pre_edge_busy", {31'd0, busy}, 32'd1);
      check("sclr_pre_edge_q", {22'd0, q_out}, 32'd928);
      @(posedge clk);
      #1;
      check("sclr_busy", {31'd0, busy}, 32'd0);
      check("sclr_valid", {31'd0, valid}, 32'd0);
      check("sclr_q", {22'd0, q_out}, 32'd0);
      check("sclr_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      sclr = 1'b0;
      watch_no_valid("sclr_no_valid");

      // sclr beats start on the same edge.
      @(negedge clk);
      sclr  = 1'b1;
      start = 1'b1;
      a_in  = 10'd5;
      b_in  = 10'd5;
      @(negedge clk);
      check("sclr_start_busy", {31'd0, busy}, 32'd0);
      sclr  = 1'b0;
      start = 1'b0;
      watch_no_valid("sclr_start_no_valid");

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative unsigned shift-add multiplier. It is the inverse-operation companion of the team's sequential divider and uses the same start/busy/valid handshake and result/flag style.
- It sits beside the divider in the arithmetic unit. A shared controller can issue operations to either block with identical control logic.
- Computes a_in * b_in at one multiplier bit per clock. Returns the low WIDTH bits and flags overflow when the full product does not fit.

Parameters:
- WIDTH, 10, operand and result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- sclr  input  1  synchronous clear, active-high. Same effect as reset, applied at the clock edge.
- start  input  1  request; sampled only when busy=0.
- a_in  input  WIDTH  multiplicand; captured on the edge where start is accepted.
- b_in  input  WIDTH  multiplier; captured on the edge where start is accepted.
- q_out  output  WIDTH  product bits [WIDTH-1:0]; held until the next accepted start.
- ovf  output  1  high when product bits [2*WIDTH-1:WIDTH] are not all zero; held with q_out.
- busy  output  1  high while an operation is in progress.
- valid  output  1  one-cycle pulse when q_out and ovf are updated.

Behaviour:
- Reset (rst_n=0, asynchronous) and sclr=1 (synchronous) have the same effect:
  - state=IDLE, busy=0, valid=0, q_out=0, ovf=0, counter=0, accumulator=0.
  - Any operation in progress is abandoned and no valid is produced for it.
  - sclr has priority over start on the same edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture A=a_in and B=b_in, clear the 2*WIDTH accumulator, counter=0, go to RUN.
  - busy=1 from that edge.
- RUN, at each edge:
  - If B[0]=1, add A (zero-extended, shifted left by counter) into the accumulator.
  - Shift B right by 1 and increment counter.
  - When counter reaches WIDTH-1 (final bit processed on this edge), go to DONE.
  - At that same edge, write the final accumulator into q_out (low WIDTH bits) and ovf (OR of the high WIDTH bits).
- DONE:
  - Lasts one cycle: valid=1, busy=0.
  - start=1 in DONE is accepted exactly as in IDLE: go to RUN, valid drops next cycle.
  - Otherwise go to IDLE.
- Latency:
  - Start accepted at edge k gives valid high in the cycle after edge k+WIDTH.
  - busy is high for exactly WIDTH cycles.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no capture, current operation unaffected.
- Operands are used only at capture. Changes to a_in/b_in while busy have no effect.
- q_out and ovf change only at the completion edge or on reset/sclr.
- Arithmetic:
  - Accumulator is 2*WIDTH bits wide; no intermediate overflow is possible.
  - Result is the exact unsigned product mod 2^WIDTH.
- A zero operand still takes the full WIDTH cycles (no early termination). Fixed latency is required by the controller.
- valid never asserts without a preceding accepted start since the last reset/sclr.

Decomposition:
- Package arith_pkg:
  - State encoding constants IDLE/RUN/DONE, shared with the divider controller.
  - Default WIDTH=10.
- One natural sub-module: mul_datapath. It holds the A/B/accumulator registers plus the adder and shifter, with load/step control inputs.
- seq_multiplier keeps the FSM, counter and output registers.

Test Plan:
- Reset 2 cycles, sclr pulse, then start with a_in=116, b_in=8 -> valid pulse 10 cycles after the accepting edge; q_out=928, ovf=0; busy high for exactly 10 cycles.
- a_in=32, b_in=32 -> q_out=0, ovf=1 (product 1024); a_in=1023, b_in=1023 -> q_out=1, ovf=1.
- a_in=0, b_in=777 -> q_out=0, ovf=0, still 10-cycle latency; a_in=1, b_in=1023 -> q_out=1023, ovf=0.
- Start held high continuously with a_in=3, b_in=5, then operands changed to 7/9 mid-operation -> first valid gives q_out=15. The start seen in the DONE cycle is accepted, and the next valid gives q_out=63 eleven cycles later.
- rst_n pulled low asynchronously (mid-cycle) at iteration 4 of 1023*1023 -> all outputs 0 immediately, no valid afterwards; repeat with sclr -> same result at the next edge.
- sclr and start both high on the same edge -> stays IDLE, busy=0, no valid.
